tsbus_rx: RTL and testbench

- Receive end of the library's half-duplex tri-state link, whose driver cell puts the inverted data onto a shared bus when its enable is high.
- Samples the shared bus and undoes the inversion.
- Buffers words in a small FIFO and presents them on a valid/ready interface.
- Returns back-pressure (BUSY) to the far-end driver's control logic and sits beside the bus keeper at the consuming side.

---
 rtl/tsbus_rx.sv | 146 ++++++++++++++
 tb/tb_tsbus_rx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsbus_rx.sv
// tsbus_rx: receive end of the half-duplex tri-state link.
// Samples the shared bus while the far-end driver is enabled, undoes the
// driver's inversion, buffers words in a FIFO and offers them on a
// valid/ready interface with back-pressure (BUSY) and sticky overflow (OVF).
//
// Optional build macro: TSBUS_RX_PARITY_EN
//   defined   -> BUS is W+1 bits (MSB = odd parity over the raw bus bits),
//                failing words are dropped and PERR pulses for one cycle.
//   undefined -> BUS is W bits, no PERR port.
//
// Ports:
//   CLK      rising-edge clock
//   RSTB     asynchronous active-low reset
//   BUS      shared tri-state bus (receive only)
//   FAR_EN   copy of the far-end driver enable
//   STB      far-end word strobe
//   RX_DATA  head-of-FIFO word (registered)
//   RX_VALID FIFO non-empty (registered)
//   RX_READY consumer accept
//   BUSY     FIFO full, decoded from registered LVL
//   OVF      sticky overflow flag
//   OVF_CLR  clears OVF
//   PERR     parity error pulse (parity build only)
//   LVL      FIFO occupancy
module tsbus_rx #(
    parameter int unsigned W      = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned INVERT = 1
) (
    input  logic                     CLK,
    input  logic                     RSTB,
`ifdef TSBUS_RX_PARITY_EN
    input  logic [W:0]               BUS,
`else
    input  logic [W-1:0]             BUS,
`endif
    input  logic                     FAR_EN,
    input  logic                     STB,
    output logic [W-1:0]             RX_DATA,
    output logic                     RX_VALID,
    input  logic                     RX_READY,
    output logic                     BUSY,
    output logic                     OVF,
    input  logic                     OVF_CLR,
`ifdef TSBUS_RX_PARITY_EN
    output logic                     PERR,
`endif
    output logic [$clog2(DEPTH):0]   LVL
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CAPT   = 2'd2
    } state_t;

    state_t         state, state_n;
    logic           strobe_c;
    logic           par_ok_c;
    logic [W-1:0]   word_c;
    logic [W-1:0]   mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr, wr_n, rd_n, lvl_n;
    logic           empty_c, full_c, pop_c, good_c, push_c, ovf_set_c;
    logic [W-1:0]   head_c;

    // Parity is checked on the raw bus, before any inversion is undone
`ifdef TSBUS_RX_PARITY_EN
    assign par_ok_c = ^BUS;
`else
    assign par_ok_c = 1'b1;
`endif

    assign word_c = (INVERT != 0) ? ~BUS[W-1:0] : BUS[W-1:0];

    // Next-state logic; strobes only count in CAPT while the far end is enabled
    always_comb begin
        state_n  = state;
        strobe_c = 1'b0;
        case (state)
            IDLE:    if (FAR_EN) state_n = SETTLE;
            SETTLE:  state_n = FAR_EN ? CAPT : IDLE;
            CAPT: begin
                if (!FAR_EN) state_n = IDLE;
                else         strobe_c = STB;
            end
            default: state_n = IDLE;
        endcase
    end

    // FIFO control: a full FIFO still accepts a push when a pop frees a slot
    always_comb begin
        empty_c   = (wr_ptr == rd_ptr);
        full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop_c     = RX_VALID && RX_READY;
        good_c    = strobe_c && par_ok_c;
        push_c    = good_c && (!full_c || pop_c);
        ovf_set_c = good_c && full_c && !pop_c;
        wr_n      = wr_ptr + PW'(push_c);
        rd_n      = rd_ptr + PW'(pop_c);
        lvl_n     = wr_n - rd_n;
        // New head is the incoming word when it lands in an otherwise empty FIFO
        head_c    = (push_c && (rd_n == wr_ptr)) ? word_c : mem[rd_n[AW-1:0]];
    end

    assign BUSY = (LVL == PW'(DEPTH));

    // Storage array, no reset needed
    always_ff @(posedge CLK) begin
        if (push_c) mem[wr_ptr[AW-1:0]] <= word_c;
    end

    // State, pointers and registered outputs
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            LVL      <= '0;
            RX_VALID <= 1'b0;
            RX_DATA  <= '0;
            OVF      <= 1'b0;
`ifdef TSBUS_RX_PARITY_EN
            PERR     <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            wr_ptr   <= wr_n;
            rd_ptr   <= rd_n;
            LVL      <= lvl_n;
            RX_VALID <= (lvl_n != '0);
            if (lvl_n != '0) RX_DATA <= head_c;
            if (ovf_set_c)    OVF <= 1'b1;
            else if (OVF_CLR) OVF <= 1'b0;
`ifdef TSBUS_RX_PARITY_EN
            PERR     <= strobe_c && !par_ok_c;
`endif
        end
    end

    logic unused_empty;
    assign unused_empty = empty_c;

endmodule

// File: tb/tb_tsbus_rx.sv
// Testbench for tsbus_rx: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the receive FIFO.
module tb_tsbus_rx;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 3;
`ifdef TSBUS_RX_PARITY_EN
    localparam int unsigned BW    = W + 1;
`else
    localparam int unsigned BW    = W;
`endif

    logic          CLK  = 1'b0;
    logic          RSTB = 1'b0;
    logic [BW-1:0] bus  = '0;
    logic          far_en = 1'b0, stb = 1'b0, rx_ready = 1'b0, ovf_clr = 1'b0;
    logic [W-1:0]  rx_data;
    logic          rx_valid, busy, ovf;
    logic [PW-1:0] lvl;
`ifdef TSBUS_RX_PARITY_EN
    logic          perr;
    logic          bad_par = 1'b0;
`endif

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model state
    logic [W-1:0] q[$];
    logic         m_ovf  = 1'b0;
    logic         m_perr = 1'b0;
    logic [W-1:0] m_data = '0;
    int           run    = 0;   // consecutive edges with FAR_EN sampled high

    always #5 CLK = ~CLK;

    tsbus_rx #(.W(W), .DEPTH(DEPTH), .INVERT(1)) dut (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .BUS      (bus),
        .FAR_EN   (far_en),
        .STB      (stb),
        .RX_DATA  (rx_data),
        .RX_VALID (rx_valid),
        .RX_READY (rx_ready),
        .BUSY     (busy),
        .OVF      (ovf),
        .OVF_CLR  (ovf_clr),
`ifdef TSBUS_RX_PARITY_EN
        .PERR     (perr),
`endif
        .LVL      (lvl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus value the far end would drive for raw (already inverted) bits w
    function automatic logic [BW-1:0] wire_of(input logic [W-1:0] w);
`ifdef TSBUS_RX_PARITY_EN
        return {~(^w) ^ bad_par, w};
`else
        return w;
`endif
    endfunction

    task automatic check_all();
        check("rx_valid", 32'(rx_valid), 32'(q.size() != 0));
        check("rx_data",  32'(rx_data),  32'(m_data));
        check("lvl",      32'(lvl),      32'(q.size()));
        check("busy",     32'(busy),     32'(q.size() == DEPTH));
        check("ovf",      32'(ovf),      32'(m_ovf));
`ifdef TSBUS_RX_PARITY_EN
        check("perr",     32'(perr),     32'(m_perr));
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare
    task automatic step(input logic fin, input logic s, input logic [W-1:0] w,
                        input logic rdy, input logic clr);
        logic capt, ok, push, pop, full, ovf_set;
        logic [W-1:0] word;
        far_en   = fin;
        stb      = s;
        bus      = wire_of(w);
        rx_ready = rdy;
        ovf_clr  = clr;
        @(posedge CLK);
        capt = (run >= 2);
`ifdef TSBUS_RX_PARITY_EN
        ok = ^bus;
`else
        ok = 1'b1;
`endif
        word    = ~bus[W-1:0];
        full    = (q.size() == DEPTH);
        pop     = (q.size() != 0) && rdy;
        push    = capt && fin && s && ok;
        m_perr  = capt && fin && s && !ok;
        ovf_set = 1'b0;
        if (pop) void'(q.pop_front());
        if (push) begin
            if (full && !pop) ovf_set = 1'b1;
            else              q.push_back(word);
        end
        if (ovf_set)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        run = fin ? ((run < 2) ? run + 1 : 2) : 0;
        if (q.size() != 0) m_data = q[0];
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        m_data = '0;
        run    = 0;
    endtask

    // Asynchronous reset check: outputs clear before any clock edge
    task automatic async_reset();
        far_en = 1'b0; stb = 1'b0; rx_ready = 1'b0; ovf_clr = 1'b0;
        #3 RSTB = 1'b0;
        #1;
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data",  32'(rx_data),  32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_ovf",   32'(ovf),      32'd0);
        check("rst_lvl",   32'(lvl),      32'd0);
        model_reset();
        @(posedge CLK);
        #1 RSTB = 1'b1;
    endtask

    // Protocol monitor: unknown bus value on a strobe
    always @(posedge CLK) begin
        if (RSTB && far_en && stb && $isunknown(bus))
            $error("FAIL bus_x got=%0h exp=known", bus);
    end

    initial begin
        logic [W-1:0] w;
        // Power-on reset
        repeat (2) @(posedge CLK);
        #1;
        check("por_valid", 32'(rx_valid), 32'd0);
        check("por_lvl",   32'(lvl),      32'd0);
        check("por_ovf",   32'(ovf),      32'd0);
        #3 RSTB = 1'b1;

        // Strobes during IDLE and SETTLE are ignored; first CAPT strobe lands
        step(1, 1, 8'h5A, 0, 0);
        step(1, 1, 8'h5A, 0, 0);
        check("settle_lvl", 32'(lvl), 32'd0);
        step(1, 1, 8'h5A, 0, 0);
        check("first_valid", 32'(rx_valid), 32'd1);
        check("first_data",  32'(rx_data),  32'hA5);
        check("first_lvl",   32'(lvl),      32'd1);
        step(1, 0, 8'h00, 1, 0);

        // Fill to full, overflow, then drain in order
        step(1, 1, 8'hFE, 0, 0);
        step(1, 1, 8'hFD, 0, 0);
        step(1, 1, 8'hFC, 0, 0);
        step(1, 1, 8'hFB, 0, 0);
        check("full_busy", 32'(busy), 32'd1);
        step(1, 1, 8'hFA, 0, 0);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_lvl", 32'(lvl), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 32'(rx_data), 32'(i));
            step(1, 0, 8'h00, 1, 0);
        end
        step(1, 0, 8'h00, 0, 1);
        check("ovf_clr", 32'(ovf), 32'd0);

        // Full FIFO with a simultaneous pop accepts the push
        step(1, 1, 8'hFE, 0, 0);
        step(1, 1, 8'hFD, 0, 0);
        step(1, 1, 8'hFC, 0, 0);
        step(1, 1, 8'hFB, 0, 0);
        step(1, 1, 8'hFA, 1, 0);
        check("pp_full_lvl", 32'(lvl), 32'd4);
        check("pp_full_ovf", 32'(ovf), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            check("pp_drain", 32'(rx_data), 32'(i));
            step(1, 0, 8'h00, 1, 0);
        end

        // Steady push+pop wraps the pointers
        step(1, 1, 8'h80, 0, 0);
        for (int i = 0; i < 9; i++) begin
            w = W'($urandom);
            step(1, 1, w, 1, 0);
            check("wrap_lvl", 32'(lvl), 32'd1);
        end
        check("wrap_ovf", 32'(ovf), 32'd0);
        step(1, 1, 8'h11, 0, 0);
        step(1, 1, 8'h22, 0, 0);
        step(1, 1, 8'h33, 0, 0);
        step(1, 1, 8'h44, 0, 1);
        check("set_beats_clr", 32'(ovf), 32'd1);
        step(1, 0, 8'h00, 0, 1);

        // FAR_EN drop in SETTLE: nothing pushed
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(1, 1, 8'h01, 0, 0);
        step(0, 1, 8'h02, 0, 0);
        step(0, 1, 8'h03, 0, 0);
        check("settle_drop", 32'(lvl), 32'd0);

        // Reset mid-CAPT with two words buffered
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        step(1, 1, 8'h0F, 0, 0);
        step(1, 1, 8'hF0, 0, 0);
        check("pre_rst_lvl", 32'(lvl), 32'd2);
        async_reset();
        step(1, 1, 8'h33, 0, 0);
        check("post_rst_idle", 32'(lvl), 32'd0);

`ifdef TSBUS_RX_PARITY_EN
        // Bad parity word is dropped with a single PERR pulse
        step(1, 0, 8'h00, 0, 0);
        step(1, 1, 8'h55, 0, 0);
        bad_par = 1'b1;
        step(1, 1, 8'h66, 0, 0);
        bad_par = 1'b0;
        check("perr_pulse", 32'(perr), 32'd1);
        check("perr_lvl",   32'(lvl),  32'd1);
        step(1, 1, 8'h77, 0, 0);
        check("perr_low",   32'(perr), 32'd0);
        check("good_lvl",   32'(lvl),  32'd2);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
`ifdef TSBUS_RX_PARITY_EN
            bad_par = ($urandom_range(7) == 0);
`endif
            step(($urandom_range(7) != 0), $urandom_range(1), W'($urandom),
                 $urandom_range(1), ($urandom_range(15) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
